pla_eval_pipe: RTL and testbench
================================

PLA_EVAL_PIPE -- requirements
Module: pla_eval_pipe

Interface
REQ-001 Parameter N_IN, default 8, number of PLA inputs (1..16).
REQ-002 Parameter N_OUT, default 27, number of PLA outputs (1..64).
REQ-003 Parameter N_TERM, default 32, number of product terms (1..64); TW = clog2(N_TERM).
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port cfg_we, input, 1, write one product term.
REQ-007 Port cfg_addr, input, TW, term index.
REQ-008 Port cfg_mask, input, N_IN, AND-plane care bits (1 = input participates).
REQ-009 Port cfg_val, input, N_IN, required input polarity where mask=1.
REQ-010 Port cfg_or, input, N_OUT, OR-plane row for the term.
REQ-011 Port cfg_ready, output, 1, config write accepted this cycle.
REQ-012 Port in_valid / in_ready / in_data, input / output / input, 1 / 1 / N_IN, input vector handshake.
REQ-013 Port out_valid / out_ready / out_data, output / input / output, 1 / 1 / N_OUT, result handshake.
REQ-014 Port act_clr, input, 1, clear activity counter (PLA_ACT_CNT_EN only).
REQ-015 Port act_cnt, output, 32, output-toggle count (PLA_ACT_CNT_EN only).

Function
REQ-016 Term t hits iff term_en[t] and ((in_data ^ val[t]) & mask[t]) == 0; all-zero mask with term_en set hits unconditionally.
REQ-017 out_data bit j = OR over hit terms t of or[t][j]; no hits -> all zeros.
REQ-018 Two-stage pipeline: S1 registers term-hit vector, S2 registers OR-plane result; latency exactly 2 cycles from in_valid&&in_ready to out_valid with no backpressure.
REQ-019 Throughput one vector per cycle while out_ready=1.
REQ-020 S2 holds out_data/out_valid stable while out_valid && !out_ready; S1 advances only when S2 empty or S2 transferring.
REQ-021 in_ready = !cfg_we && (!s1_valid || s1_advance); simultaneous cfg_we and in_valid: config wins, input stalls.
REQ-022 cfg_ready = !s1_valid && !s2_valid; a cfg_we write commits only when cfg_ready=1, otherwise ignored, and is visible to the first vector accepted after it.
REQ-023 Write commit sets term_en[cfg_addr]=1 and stores mask/val/or; cfg_addr >= N_TERM is ignored.
REQ-024 Planes are stable while data in flight (guaranteed by REQ-022); no read-during-write hazard exists.

Reset
REQ-025 rst clears s1_valid, s2_valid, out_data, term_en (all terms disabled), act_cnt, and the previous-output register; out_valid=0, cfg_ready=1 and in_ready=1 the cycle after rst falls.
REQ-026 rst mid-operation discards in-flight vectors with no output transfer; mask/val/or contents need not be reset.

Configuration
REQ-027 Macro PLA_ACT_CNT_EN defined: act_cnt adds popcount(out_data ^ prev_out) on each output transfer, then prev_out <= out_data; saturates at 2^32-1; act_clr zeroes it next cycle (clear wins over increment).
REQ-028 Macro undefined: act_clr ignored, act_cnt tied to 0, no counter or prev_out flops.

Structure
REQ-029 Package pla_pkg holds default N_IN/N_OUT/N_TERM constants, act-counter width (32) and term-record typedef {en, mask, val, or}.
REQ-030 Sub-module pla_and_plane computes the combinational N_TERM-bit hit vector from in_data and the plane arrays; OR-plane, pipeline and counter stay in the top.

Verification
REQ-031 Reset, no config, send in_data=8'hA5 -> out_data=0 after 2 cycles, act_cnt=0.
REQ-032 Term 0 mask=8'h0F val=8'h05 or=bit0; term 1 mask=0 or=bit26; in_data=8'h35 -> out_data bits 0 and 26 set; in_data=8'h36 -> only bit 26.
REQ-033 Stream 10 vectors with out_ready low cycles 3-5 -> no loss/duplication, order preserved, out_data stable while stalled.
REQ-034 cfg_we with 2 vectors in flight -> cfg_ready=0, write ignored; repeat after drain -> committed, next vector uses new term.
REQ-035 PLA_ACT_CNT_EN: outputs 0, 27'h7FFFFFF, 27'h0000001 -> act_cnt=27, then 53; act_clr -> 0; without macro act_cnt stays 0.
REQ-036 Assert rst with both stages valid -> out_valid=0 next cycle, term_en cleared, subsequent vector yields 0.

Source files
------------

// File: rtl/pla_pkg.sv
// Shared constants and types for the pipelined PLA evaluator.
package pla_pkg;

  localparam int N_IN_DEF   = 8;
  localparam int N_OUT_DEF  = 27;
  localparam int N_TERM_DEF = 32;
  localparam int ACT_W      = 32;

  // One product term as seen at the default geometry.
  typedef struct packed {
    logic                 en;
    logic [N_IN_DEF-1:0]  mask;
    logic [N_IN_DEF-1:0]  val;
    logic [N_OUT_DEF-1:0] or_row;
  } term_t;

  // Term index width; a single-term PLA still gets a 1-bit address.
  function automatic int term_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pla_and_plane.sv
// Combinational AND plane: one hit bit per enabled product term.
module pla_and_plane
  import pla_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_TERM = N_TERM_DEF
) (
  input  logic [N_IN-1:0]              in_data,
  input  logic [N_TERM-1:0]            term_en,
  input  logic [N_TERM-1:0][N_IN-1:0]  mask,
  input  logic [N_TERM-1:0][N_IN-1:0]  val,
  output logic [N_TERM-1:0]            hit
);

  // A term hits when every cared-for input matches its polarity; empty mask always hits.
  always_comb begin
    hit = '0;
    for (int unsigned t = 0; t < N_TERM; t++) begin
      hit[t] = term_en[t] && (((in_data ^ val[t]) & mask[t]) == '0);
    end
  end

endmodule

// File: rtl/pla_eval_pipe.sv
// Two-stage pipelined PLA evaluator with a runtime-programmable AND/OR plane.
// Optional output-toggle activity counter enabled by defining PLA_ACT_CNT_EN.
module pla_eval_pipe
  import pla_pkg::*;
#(
  parameter  int N_IN   = N_IN_DEF,
  parameter  int N_OUT  = N_OUT_DEF,
  parameter  int N_TERM = N_TERM_DEF,
  localparam int TW     = term_w(N_TERM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [TW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_mask,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [N_OUT-1:0] cfg_or,
  output logic             cfg_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  input  logic             act_clr,
  output logic [ACT_W-1:0] act_cnt
);

  logic [N_TERM-1:0]            term_en;
  logic [N_TERM-1:0][N_IN-1:0]  mask_q;
  logic [N_TERM-1:0][N_IN-1:0]  val_q;
  logic [N_TERM-1:0][N_OUT-1:0] or_q;

  logic [N_TERM-1:0] hit;
  logic [N_TERM-1:0] s1_hit;
  logic              s1_valid;
  logic              s2_valid;
  logic [N_OUT-1:0]  or_res;
  logic              s2_free;
  logic              s1_load;
  logic              in_fire;
  logic              cfg_commit;

  // S1 may load when empty or when S2 can take its contents this cycle.
  assign s2_free    = !s2_valid || out_ready;
  assign s1_load    = !s1_valid || s2_free;
  assign in_ready   = !cfg_we && s1_load;
  assign in_fire    = in_valid && in_ready;
  assign cfg_ready  = !s1_valid && !s2_valid;
  assign cfg_commit = cfg_we && cfg_ready && (32'(cfg_addr) < N_TERM);
  assign out_valid  = s2_valid;

  pla_and_plane #(
    .N_IN   (N_IN),
    .N_TERM (N_TERM)
  ) u_and_plane (
    .in_data (in_data),
    .term_en (term_en),
    .mask    (mask_q),
    .val     (val_q),
    .hit     (hit)
  );

  // Term enables are the only plane state that reset must clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      term_en <= '0;
    end else if (cfg_commit) begin
      term_en[cfg_addr] <= 1'b1;
    end
  end

  // Plane contents; pipeline is empty whenever a write commits.
  always_ff @(posedge clk) begin
    if (cfg_commit) begin
      mask_q[cfg_addr] <= cfg_mask;
      val_q[cfg_addr]  <= cfg_val;
      or_q[cfg_addr]   <= cfg_or;
    end
  end

  // OR plane over the registered hit vector.
  always_comb begin
    or_res = '0;
    for (int unsigned t = 0; t < N_TERM; t++) begin
      if (s1_hit[t]) or_res = or_res | or_q[t];
    end
  end

  // Stage 1: capture the hit vector of an accepted input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_fire;
      if (in_fire) s1_hit <= hit;
    end
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) out_data <= or_res;
    end
  end

`ifdef PLA_ACT_CNT_EN
  logic [N_OUT-1:0] prev_out;
  logic [ACT_W-1:0] act_q;
  logic [ACT_W:0]   act_sum;
  logic             out_fire;

  assign out_fire = s2_valid && out_ready;
  assign act_sum  = {1'b0, act_q} + (ACT_W+1)'($countones(out_data ^ prev_out));
  assign act_cnt  = act_q;

  // Saturating toggle counter; clear takes priority over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q    <= '0;
      prev_out <= '0;
    end else begin
      if (out_fire) prev_out <= out_data;
      if (act_clr) begin
        act_q <= '0;
      end else if (out_fire) begin
        act_q <= act_sum[ACT_W] ? '1 : act_sum[ACT_W-1:0];
      end
    end
  end
`else
  logic unused_act_clr;
  assign unused_act_clr = act_clr;
  assign act_cnt        = '0;
`endif

endmodule

// File: tb/tb_pla_eval_pipe.sv
// Directed self-checking bench for pla_eval_pipe (default geometry 8/27/32).
module tb_pla_eval_pipe;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_mask;
  logic [7:0]  cfg_val;
  logic [26:0] cfg_or;
  logic        cfg_ready;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] out_data;
  logic        act_clr;
  logic [31:0] act_cnt;

  int checks = 0;
  int errors = 0;

  pla_eval_pipe #(
    .N_IN   (8),
    .N_OUT  (27),
    .N_TERM (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_mask  (cfg_mask),
    .cfg_val   (cfg_val),
    .cfg_or    (cfg_or),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .act_clr   (act_clr),
    .act_cnt   (act_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] vec(input int i);
    return 8'(i * 29 + 7);
  endfunction

  task automatic cfg_write(input int a, input logic [7:0] m, input logic [7:0] v,
                           input logic [26:0] o);
    int n;
    n = 0;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_wait: cfg_ready=%b expected 1", cfg_ready);
    end
    cfg_we   = 1'b1;
    cfg_addr = 5'(a);
    cfg_mask = m;
    cfg_val  = v;
    cfg_or   = o;
    tick();
    cfg_we = 1'b0;
  endtask

  // Sends one vector with out_ready high and returns the resulting output.
  task automatic run_vec(input logic [7:0] d, output logic [26:0] q, output bit ok);
    int n;
    ok = 1'b0;
    q  = '0;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    ok = out_valid;
    q  = out_data;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_val = '0; cfg_or = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; act_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b expected 1", cfg_ready); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== 27'h0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    checks++; if (act_cnt !== 32'h0) begin errors++; $display("FAIL rst_act_cnt: got %0d expected 0", act_cnt); end
  endtask

  task automatic test_no_config();
    out_ready = 1'b1;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cycle1: out_valid=%b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_cycle2: out_valid=%b expected 1", out_valid); end
    checks++; if (out_data !== 27'h0) begin errors++; $display("FAIL noconf_data: got %h expected 0", out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL noconf_drain: out_valid=%b expected 0", out_valid); end
    checks++; if (act_cnt !== 32'h0) begin errors++; $display("FAIL noconf_act: got %0d expected 0", act_cnt); end
  endtask

  task automatic test_logic();
    logic [26:0] q;
    bit ok;
    cfg_write(0, 8'h0F, 8'h05, 27'h0000001);
    cfg_write(1, 8'h00, 8'h00, 27'h4000000);
    run_vec(8'h35, q, ok);
    checks++; if (!ok || q !== 27'h4000001) begin errors++; $display("FAIL logic_35: got %h ok=%b expected 4000001", q, ok); end
    run_vec(8'h36, q, ok);
    checks++; if (!ok || q !== 27'h4000000) begin errors++; $display("FAIL logic_36: got %h ok=%b expected 4000000", q, ok); end
    run_vec(8'hF5, q, ok);
    checks++; if (!ok || q !== 27'h4000001) begin errors++; $display("FAIL logic_F5: got %h ok=%b expected 4000001", q, ok); end
  endtask

  // Identity plane: term t matches in bit t high and drives out bit t.
  task automatic load_identity();
    for (int t = 0; t < 8; t++) begin
      cfg_write(t, 8'(1 << t), 8'(1 << t), 27'(1 << t));
    end
  endtask

  task automatic test_back_to_back();
    int ni;
    int no;
    bit hold;
    bit fire_in;
    logic [26:0] held;
    do_reset();
    out_ready = 1'b1;
    load_identity();
    ni = 0; no = 0; hold = 1'b0; held = '0;
    in_data  = vec(0);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && no < 10; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== {19'h0, vec(no)}) begin
          errors++;
          $display("FAIL stream_%0d: got %h expected %h", no, out_data, {19'h0, vec(no)});
        end
        no++;
      end
      hold    = out_valid && !out_ready;
      held    = out_data;
      fire_in = in_valid && in_ready;
      tick();
      if (fire_in) begin
        ni++;
        if (ni < 10) in_data = vec(ni);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++; if (no != 10) begin errors++; $display("FAIL stream_count: got %0d expected 10", no); end
    out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_extra: out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_cfg_in_flight();
    logic [26:0] q;
    bit ok;
    int got;
    out_ready = 1'b0;
    in_data   = 8'h12;
    in_valid  = 1'b1;
    tick();
    in_data = 8'h34;
    tick();
    in_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL flight_cfg_ready: got %b expected 0", cfg_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flight_in_ready: got %b expected 0", in_ready); end
    cfg_we = 1'b1; cfg_addr = 5'd10; cfg_mask = 8'h00; cfg_val = 8'h00; cfg_or = 27'h2000000;
    tick();
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 10 && got < 2; n++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (out_data !== (got == 0 ? 27'h12 : 27'h34)) begin
          errors++;
          $display("FAIL flight_out%0d: got %h expected %h", got, out_data, (got == 0 ? 27'h12 : 27'h34));
        end
        got++;
      end
      tick();
    end
    checks++; if (got != 2) begin errors++; $display("FAIL flight_count: got %0d expected 2", got); end
    run_vec(8'h00, q, ok);
    checks++; if (!ok || q !== 27'h0) begin errors++; $display("FAIL cfg_ignored: got %h ok=%b expected 0", q, ok); end
    cfg_write(10, 8'h00, 8'h00, 27'h2000000);
    run_vec(8'h00, q, ok);
    checks++; if (!ok || q !== 27'h2000000) begin errors++; $display("FAIL cfg_commit: got %h ok=%b expected 2000000", q, ok); end
    run_vec(8'h81, q, ok);
    checks++; if (!ok || q !== 27'h2000081) begin errors++; $display("FAIL cfg_commit_81: got %h ok=%b expected 2000081", q, ok); end
  endtask

  task automatic test_act();
    logic [26:0] q;
    bit ok;
    logic [31:0] e1, e2, e3;
`ifdef PLA_ACT_CNT_EN
    e1 = 32'd27; e2 = 32'd53; e3 = 32'd26;
`else
    e1 = 32'd0;  e2 = 32'd0;  e3 = 32'd0;
`endif
    do_reset();
    out_ready = 1'b1;
    cfg_write(0, 8'hFF, 8'h11, 27'h7FFFFFF);
    cfg_write(1, 8'hFF, 8'h22, 27'h0000001);
    run_vec(8'h00, q, ok);
    checks++; if (!ok || q !== 27'h0) begin errors++; $display("FAIL act_out0: got %h ok=%b expected 0", q, ok); end
    checks++; if (act_cnt !== 32'd0) begin errors++; $display("FAIL act_cnt0: got %0d expected 0", act_cnt); end
    run_vec(8'h11, q, ok);
    checks++; if (!ok || q !== 27'h7FFFFFF) begin errors++; $display("FAIL act_out1: got %h ok=%b expected 7ffffff", q, ok); end
    checks++; if (act_cnt !== e1) begin errors++; $display("FAIL act_cnt1: got %0d expected %0d", act_cnt, e1); end
    run_vec(8'h22, q, ok);
    checks++; if (act_cnt !== e2) begin errors++; $display("FAIL act_cnt2: got %0d expected %0d", act_cnt, e2); end
    act_clr = 1'b1;
    tick();
    act_clr = 1'b0;
    checks++; if (act_cnt !== 32'd0) begin errors++; $display("FAIL act_clr: got %0d expected 0", act_cnt); end
    run_vec(8'h11, q, ok);
    checks++; if (act_cnt !== e3) begin errors++; $display("FAIL act_cnt3: got %0d expected %0d", act_cnt, e3); end
  endtask

  task automatic test_reset_mid();
    logic [26:0] q;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    cfg_write(0, 8'h00, 8'h00, 27'h7FFFFFF);
    out_ready = 1'b0;
    in_data   = 8'h01;
    in_valid  = 1'b1;
    tick();
    in_data = 8'h02;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_full: v=%b cfg_ready=%b expected 1/0", out_valid, cfg_ready); end
    rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_cfg_ready: got %b expected 1", cfg_ready); end
    rst = 1'b0;
    out_ready = 1'b1;
    run_vec(8'h5A, q, ok);
    checks++; if (!ok || q !== 27'h0) begin errors++; $display("FAIL mid_term_en: got %h ok=%b expected 0", q, ok); end
  endtask

  initial begin
    test_reset();
    test_no_config();
    test_logic();
    test_back_to_back();
    test_cfg_in_flight();
    test_act();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
